// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types, constants and helpers for the PUF response engine
//
// Purpose : FSM state encoding, default LFSR feedback mask and a request
//           latency helper shared by the engine and its benches.
// Ports   : none (package).
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRECHG = 3'd1,
    LAUNCH = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } puf_state_e;

  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;

  // Cycles from the start-sampling edge to the edge that raises rsp_valid.
  function automatic int unsigned puf_latency(input int unsigned n_bits,
                                              input int unsigned n_repeat,
                                              input int unsigned settle);
    return n_bits * (n_repeat * (2 * settle + 2) + 1);
  endfunction

endpackage

// File: rtl/puf_response_engine_if.sv
// rtl/puf_response_engine_if.sv - host-side request/response interface of the PUF engine
//
// Purpose : groups the host command and response handshake signals.
// Signals : start/seed     request pulse and challenge seed (host -> engine)
//           busy           engine occupied (engine -> host)
//           rsp_valid/rsp_ready/rsp/unstable_cnt  response handshake
// Modports: master (host side), slave (engine side).
interface puf_response_engine_if #(
  parameter int WIDTH  = 32,
  parameter int N_BITS = 32
);
  localparam int CW = $clog2(N_BITS + 1);

  logic              start;
  logic [WIDTH-1:0]  seed;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N_BITS-1:0] rsp;
  logic [CW-1:0]     unstable_cnt;

  modport master (
    output start, seed, rsp_ready,
    input  busy, rsp_valid, rsp, unstable_cnt
  );

  modport slave (
    input  start, seed, rsp_ready,
    output busy, rsp_valid, rsp, unstable_cnt
  );

endinterface

// File: rtl/puf_challenge_lfsr.sv
// rtl/puf_challenge_lfsr.sv - challenge LFSR with seed load and rotated operand outputs
//
// Purpose : holds the challenge state; loads a seed (zero seed forced to 1 so
//           the register never locks up) and advances once per response bit.
// Ports   : clk, rst_n         clock, async active-low reset
//           load, seed         load request and seed value
//           advance            shift one step
//           chal_a, chal_b     lfsr and lfsr rotated left by WIDTH/2
module puf_challenge_lfsr
  import puf_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] chal_a,
  output logic [WIDTH-1:0] chal_b
);

  localparam int ROT = WIDTH / 2;

  logic [WIDTH-1:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= (seed == '0) ? WIDTH'(1) : seed;
    end else if (advance) begin
      lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    end
  end

  assign chal_a = lfsr;
  assign chal_b = {lfsr[WIDTH-ROT-1:0], lfsr[WIDTH-1:WIDTH-ROT]};

endmodule

// File: rtl/puf_response_engine.sv
// rtl/puf_response_engine.sv - arbiter PUF sequencer with majority-voted response bits
//
// Purpose : per response bit, runs N_REPEAT precharge/launch evaluations of
//           the external adder/PDL/arbiter fabric, majority-votes them, and
//           assembles an N_BITS response plus a count of split-vote bits.
// Ports   : clk, rst_n     clock, async active-low reset
//           host (slave)   start/seed request, busy, rsp handshake
//           op_a, op_b     registered operands to both adder paths
//           arb_clr        clear pulse to the arbiter flop
//           arb_in         asynchronous arbiter output (synchronised here)
module puf_response_engine
  import puf_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               N_BITS   = 32,
  parameter int               N_REPEAT = 7,
  parameter int               SETTLE   = 4,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  puf_response_engine_if.slave  host,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic                  arb_clr,
  input  logic                  arb_in
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam int RW = $clog2(N_REPEAT + 1);
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int PW = $clog2(SETTLE + 2);

  puf_state_e        state, state_n;
  logic [PW-1:0]     phase_cnt;
  logic [RW-1:0]     rep_cnt;
  logic [RW-1:0]     vote_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              arb_s1, arb_s2;
  logic [N_BITS-1:0] rsp_q;
  logic [CW-1:0]     unstable_q;
  logic              busy_q, rsp_valid_q;
  logic [WIDTH-1:0]  chal_a, chal_b;

  logic              accept;
  logic              eval_done;
  logic              last_bit;

  puf_challenge_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .seed    (host.seed),
    .advance (state == DECIDE),
    .chal_a  (chal_a),
    .chal_b  (chal_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    eval_done = 1'b0;
    last_bit  = (bit_cnt == BW'(N_BITS - 1));
    case (state)
      IDLE: begin
        if (host.start) begin
          accept  = 1'b1;
          state_n = PRECHG;
        end
      end
      PRECHG: begin
        if (phase_cnt == PW'(SETTLE - 1)) state_n = LAUNCH;
      end
      LAUNCH: begin
        // Two extra cycles cover the synchroniser so the sampled value
        // reflects this evaluation's race, not the previous one.
        if (phase_cnt == PW'(SETTLE + 1)) begin
          eval_done = 1'b1;
          state_n   = (rep_cnt == RW'(N_REPEAT - 1)) ? DECIDE : PRECHG;
        end
      end
      DECIDE: begin
        state_n = last_bit ? DONE : PRECHG;
      end
      DONE: begin
        if (host.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_s1      <= 1'b0;
      arb_s2      <= 1'b0;
      phase_cnt   <= '0;
      rep_cnt     <= '0;
      vote_cnt    <= '0;
      bit_cnt     <= '0;
      rsp_q       <= '0;
      unstable_q  <= '0;
      op_a        <= '0;
      op_b        <= '0;
      arb_clr     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      arb_s1 <= arb_in;
      arb_s2 <= arb_s1;

      if ((state_n != state) || !((state == PRECHG) || (state == LAUNCH))) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + PW'(1);
      end

      if (accept) begin
        rsp_q      <= '0;
        unstable_q <= '0;
        vote_cnt   <= '0;
        rep_cnt    <= '0;
        bit_cnt    <= '0;
      end

      if (eval_done) begin
        vote_cnt <= vote_cnt + RW'(arb_s2);
        rep_cnt  <= rep_cnt + RW'(1);
      end

      if (state == DECIDE) begin
        rsp_q[bit_cnt] <= (vote_cnt > RW'(N_REPEAT / 2));
        if ((vote_cnt != '0) && (vote_cnt != RW'(N_REPEAT))) begin
          unstable_q <= unstable_q + CW'(1);
        end
        vote_cnt <= '0;
        rep_cnt  <= '0;
        // Hold at the last index rather than wrapping past N_BITS-1.
        if (!last_bit) bit_cnt <= bit_cnt + BW'(1);
      end

      // Outputs are registered from the next state so they change on the
      // same edge as the state they belong to.
      op_a        <= (state_n == LAUNCH) ? chal_a : '0;
      op_b        <= (state_n == LAUNCH) ? chal_b : '0;
      arb_clr     <= (state_n == PRECHG);
      busy_q      <= (state_n != IDLE);
      rsp_valid_q <= (state_n == DONE);
    end
  end

  assign host.busy         = busy_q;
  assign host.rsp_valid    = rsp_valid_q;
  assign host.rsp          = rsp_q;
  assign host.unstable_cnt = unstable_q;

endmodule

// File: tb/tb_puf_response_engine.sv
// tb/tb_puf_response_engine.sv - directed self-checking bench for puf_response_engine
module tb_puf_response_engine;
  import puf_pkg::*;

  localparam int WIDTH    = 32;
  localparam int N_BITS   = 32;
  localparam int N_REPEAT = 7;
  localparam int SETTLE   = 4;
  localparam int LAT      = 2272;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op_a, op_b;
  logic        arb_clr;
  logic        arb_in = 1'b0;

  always #5 clk = ~clk;

  puf_response_engine_if #(.WIDTH(WIDTH), .N_BITS(N_BITS)) host ();

  puf_response_engine #(
    .WIDTH    (WIDTH),
    .N_BITS   (N_BITS),
    .N_REPEAT (N_REPEAT),
    .SETTLE   (SETTLE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (host),
    .op_a    (op_a),
    .op_b    (op_b),
    .arb_clr (arb_clr),
    .arb_in  (arb_in)
  );

  int tests = 0;
  int fails = 0;

  // Arbiter model: evaluation k of each bit returns 1 when k < ones_thresh.
  int          ones_thresh = 7;
  int          lc = 0;
  logic        prev_clr = 1'b0;
  logic [31:0] l0a, l0b, l7a, l7b;
  logic        first_clr;
  logic [31:0] first_opa;

  always @(posedge clk) begin
    #1;
    if (prev_clr && !arb_clr) begin
      if (lc == 0) begin l0a = op_a; l0b = op_b; end
      if (lc == 7) begin l7a = op_a; l7b = op_b; end
      arb_in = ((lc % N_REPEAT) < ones_thresh);
      lc++;
    end
    prev_clr = arb_clr;
  end

  task automatic run_request(input logic [31:0] s, input int thr, output int cyc);
    ones_thresh = thr;
    lc = 0;
    @(negedge clk);
    host.seed  = s;
    host.start = 1'b1;
    @(posedge clk);
    #1;
    host.start = 1'b0;
    first_clr = arb_clr;
    first_opa = op_a;
    cyc = 0;
    while (!host.rsp_valid && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!host.rsp_valid) begin
      tests++; fails++;
      $display("FAIL timeout waiting rsp_valid: got %0d cycles, need %0d", cyc, LAT);
    end
  endtask

  task automatic handshake(input logic [31:0] exp_rsp);
    @(negedge clk);
    host.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    host.rsp_ready = 1'b0;
    tests++;
    if (host.rsp_valid !== 1'b0 || host.busy !== 1'b0) begin
      fails++;
      $display("FAIL handshake: rsp_valid=%b busy=%b, need 0 0", host.rsp_valid, host.busy);
    end
    tests++;
    if (host.rsp !== exp_rsp) begin
      fails++;
      $display("FAIL rsp_kept: got %h, need %h", host.rsp, exp_rsp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (op_a !== 32'h0 || op_b !== 32'h0 || arb_clr !== 1'b0) begin
      fails++;
      $display("FAIL reset_fabric: op_a=%h op_b=%h arb_clr=%b, need 0", op_a, op_b, arb_clr);
    end
    tests++;
    if (host.busy !== 1'b0 || host.rsp_valid !== 1'b0 || host.rsp !== 32'h0 || host.unstable_cnt !== 6'd0) begin
      fails++;
      $display("FAIL reset_host: busy=%b valid=%b rsp=%h unst=%0d, need 0", host.busy, host.rsp_valid, host.rsp, host.unstable_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    int cyc;
    run_request(32'h1, 7, cyc);
    tests++;
    if (cyc !== LAT) begin fails++; $display("FAIL ones_latency: got %0d, need %0d", cyc, LAT); end
    tests++;
    if (first_clr !== 1'b1 || first_opa !== 32'h0) begin
      fails++; $display("FAIL ones_prechg: arb_clr=%b op_a=%h, need 1 0", first_clr, first_opa);
    end
    tests++;
    if (l0a !== 32'h1 || l0b !== 32'h0001_0000) begin
      fails++; $display("FAIL ones_first_ops: op_a=%h op_b=%h, need 00000001 00010000", l0a, l0b);
    end
    tests++;
    if (l7a !== 32'h3 || l7b !== 32'h0003_0000) begin
      fails++; $display("FAIL ones_bit1_ops: op_a=%h op_b=%h, need 00000003 00030000", l7a, l7b);
    end
    tests++;
    if (host.rsp !== 32'hFFFF_FFFF || host.unstable_cnt !== 6'd0) begin
      fails++; $display("FAIL ones_rsp: rsp=%h unst=%0d, need ffffffff 0", host.rsp, host.unstable_cnt);
    end
    handshake(32'hFFFF_FFFF);
  endtask

  task automatic test_all_zeros();
    int cyc;
    run_request(32'hDEAD_BEEF, 0, cyc);
    tests++;
    if (cyc !== LAT) begin fails++; $display("FAIL zeros_latency: got %0d, need %0d", cyc, LAT); end
    tests++;
    if (l0a !== 32'hDEAD_BEEF || l0b !== 32'hBEEF_DEAD) begin
      fails++; $display("FAIL zeros_first_ops: op_a=%h op_b=%h, need deadbeef beefdead", l0a, l0b);
    end
    tests++;
    if (host.rsp !== 32'h0 || host.unstable_cnt !== 6'd0) begin
      fails++; $display("FAIL zeros_rsp: rsp=%h unst=%0d, need 0 0", host.rsp, host.unstable_cnt);
    end
    handshake(32'h0);
  endtask

  task automatic test_majority();
    int cyc;
    run_request(32'h1234_5678, 4, cyc);
    tests++;
    if (host.rsp !== 32'hFFFF_FFFF || host.unstable_cnt !== 6'd32) begin
      fails++; $display("FAIL maj4_rsp: rsp=%h unst=%0d, need ffffffff 32", host.rsp, host.unstable_cnt);
    end
    handshake(32'hFFFF_FFFF);
    run_request(32'h1234_5678, 3, cyc);
    tests++;
    if (host.rsp !== 32'h0 || host.unstable_cnt !== 6'd32) begin
      fails++; $display("FAIL maj3_rsp: rsp=%h unst=%0d, need 0 32", host.rsp, host.unstable_cnt);
    end
    handshake(32'h0);
  endtask

  task automatic test_hold_done();
    int cyc;
    int bad;
    run_request(32'h1, 7, cyc);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      host.start = (i == 10);
      host.seed  = 32'h0000_0055;
      @(posedge clk);
      #1;
      if (host.rsp_valid !== 1'b1 || host.busy !== 1'b1 || host.rsp !== 32'hFFFF_FFFF) bad++;
    end
    host.start = 1'b0;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL hold_done: %0d bad cycles, need 0", bad); end
    handshake(32'hFFFF_FFFF);
    run_request(32'h1, 7, cyc);
    tests++;
    if (cyc !== LAT) begin fails++; $display("FAIL restart_latency: got %0d, need %0d", cyc, LAT); end
    // Start and handshake together in DONE: the handshake wins.
    @(negedge clk);
    host.start = 1'b1;
    host.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    host.start = 1'b0;
    host.rsp_ready = 1'b0;
    tests++;
    if (host.busy !== 1'b0 || host.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL start_with_hs: busy=%b valid=%b, need 0 0", host.busy, host.rsp_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (host.busy !== 1'b0 || arb_clr !== 1'b0) begin
      fails++; $display("FAIL start_not_queued: busy=%b arb_clr=%b, need 0 0", host.busy, arb_clr);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int guard;
    ones_thresh = 7;
    lc = 0;
    @(negedge clk);
    host.seed  = 32'h1;
    host.start = 1'b1;
    @(posedge clk);
    #1;
    host.start = 1'b0;
    guard = 0;
    while (lc < 71 && guard < 3000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    tests++;
    if (lc < 71 || op_a === 32'h0) begin
      fails++; $display("FAIL mid_reach_bit10: launches=%0d op_a=%h, need 71 nonzero", lc, op_a);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (op_a !== 32'h0 || op_b !== 32'h0 || arb_clr !== 1'b0 || host.busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset_fabric: op_a=%h op_b=%h clr=%b busy=%b, need 0", op_a, op_b, arb_clr, host.busy);
    end
    tests++;
    if (host.rsp_valid !== 1'b0 || host.rsp !== 32'h0 || host.unstable_cnt !== 6'd0) begin
      fails++; $display("FAIL mid_reset_rsp: valid=%b rsp=%h unst=%0d, need 0", host.rsp_valid, host.rsp, host.unstable_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (host.busy !== 1'b0 || arb_clr !== 1'b0) begin
      fails++; $display("FAIL mid_idle_after: busy=%b arb_clr=%b, need 0 0", host.busy, arb_clr);
    end
    run_request(32'h1, 7, cyc);
    tests++;
    if (cyc !== LAT || host.rsp !== 32'hFFFF_FFFF || l0a !== 32'h1) begin
      fails++; $display("FAIL mid_fresh: lat=%0d rsp=%h op_a=%h, need %0d ffffffff 00000001", cyc, host.rsp, l0a, LAT);
    end
    handshake(32'hFFFF_FFFF);
  endtask

  task automatic test_seed_zero();
    int cyc;
    run_request(32'h0, 7, cyc);
    tests++;
    if (l0a !== 32'h1 || l0b !== 32'h0001_0000) begin
      fails++; $display("FAIL seed0_first_ops: op_a=%h op_b=%h, need 00000001 00010000", l0a, l0b);
    end
    tests++;
    if (l7a !== 32'h3 || l7b !== 32'h0003_0000) begin
      fails++; $display("FAIL seed0_bit1_ops: op_a=%h op_b=%h, need 00000003 00030000", l7a, l7b);
    end
    tests++;
    if (cyc !== LAT || host.rsp !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL seed0_rsp: lat=%0d rsp=%h, need %0d ffffffff", cyc, host.rsp, LAT);
    end
    handshake(32'hFFFF_FFFF);
  endtask

  initial begin
    host.start     = 1'b0;
    host.seed      = '0;
    host.rsp_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_majority();
    test_hold_done();
    test_reset_mid();
    test_seed_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/puf_response_engine.md
Name: puf_response_engine

Overview:
- Parametrised successor to the dual-adder/PDL arbiter PUF core: sequences challenges into the two adder paths, clears and samples the external race arbiter, and majority-votes N_REPEAT evaluations per response bit.
- Assembles an N_BITS response word and counts unstable (non-unanimous) bits.
- Sits between the host/ethernet command logic and the adder/PDL/arbiter fabric. It drives operand registers and reads the arbiter output.

Parameters:
- WIDTH, 32, operand width driven to both adder paths.
- N_BITS, 32, response bits per request.
- N_REPEAT, 7, evaluations per bit. Must be odd and ≥1.
- SETTLE, 4, cycles the operands are held per phase. Must be ≥1.
- TAPS, 32'h80200003, LFSR feedback mask (WIDTH bits).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- seed  in  WIDTH  challenge seed, captured with start
- op_a  out  WIDTH  registered operand A to both adder paths
- op_b  out  WIDTH  registered operand B to both adder paths
- arb_clr  out  1  clear pulse to the external arbiter flop
- arb_in  in  1  asynchronous arbiter output (race winner)
- busy  out  1  high from start acceptance until the response handshake
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp  out  N_BITS  response word
- unstable_cnt  out  $clog2(N_BITS+1)  bits with split votes

Behaviour:
- Reset, asynchronous: all outputs 0; lfsr = 0; state IDLE; sync flops 0.
- arb_in passes through a 2-flop synchroniser. Only the synchronised value is used.
- LFSR: next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. On start, lfsr is loaded with seed, or with 1 if seed == 0.
- Challenge operands: op_a = lfsr; op_b = lfsr rotated left by WIDTH/2.
- States: IDLE, PRECHG, LAUNCH, DECIDE, DONE.
- IDLE: busy = 0. On start, capture seed, clear rsp, unstable_cnt and counters, then go to PRECHG.
- PRECHG, SETTLE cycles:
  - op_a = op_b = 0, so both sums are 0 and the PDL inputs idle low.
  - arb_clr = 1.
- LAUNCH, SETTLE+2 cycles:
  - op_a/op_b = challenge operands; arb_clr = 0.
  - On the last cycle, sample sync arb_in and add it to vote_cnt.
  - rep_cnt increments. If rep_cnt < N_REPEAT go to PRECHG, else go to DECIDE.
- DECIDE, 1 cycle:
  - rsp[bit_cnt] = (vote_cnt > N_REPEAT/2). The first decided bit is rsp[0].
  - If 0 < vote_cnt < N_REPEAT, unstable_cnt increments.
  - lfsr advances once; vote_cnt and rep_cnt clear; bit_cnt increments.
  - If bit_cnt == N_BITS-1, go to DONE; else go to PRECHG.
- DONE:
  - rsp_valid = 1; rsp and unstable_cnt are held stable.
  - op_a = op_b = 0.
  - On rsp_valid & rsp_ready: rsp_valid drops the next cycle and the state returns to IDLE. rsp keeps its value until the next start.
- Latency: rsp_valid rises exactly N_BITS*(N_REPEAT*(2*SETTLE+2)+1) cycles after the cycle in which start is sampled.
- start while busy, including in DONE, is ignored and not queued.
- rsp_ready outside DONE is ignored.
- Start and handshake in the same DONE cycle: the handshake completes and start is ignored.
- Reset mid-request: the request is abandoned, all outputs return to reset values, and no partial response is exposed.
- Counter widths: vote_cnt and rep_cnt use $clog2(N_REPEAT+1); bit_cnt uses $clog2(N_BITS). None of them wrap within a request.

Decomposition:
- Shared package puf_pkg holds:
  - state enum (IDLE, PRECHG, LAUNCH, DECIDE, DONE)
  - default TAPS constant
  - a function computing the request latency, for benches.
- One sub-module, puf_challenge_lfsr: seed load, advance enable, rotated operand outputs.
- The synchroniser and vote logic stay inline.

Test Plan:
- Defaults, seed = 1, arb_in tied 1:
  - the first LAUNCH drives op_a = 0x00000001 and op_b = 0x00010000;
  - rsp = 0xFFFFFFFF, unstable_cnt = 0;
  - rsp_valid rises exactly 2272 cycles after start.
- arb_in tied 0, seed = 0xDEADBEEF → rsp = 0x00000000, unstable_cnt = 0. The first LAUNCH op_a = 0xDEADBEEF and op_b = 0xBEEFDEAD.
- arb_in model returns 1 for evaluations 0–3 and 0 for 4–6 of each bit → rsp = 0xFFFFFFFF, unstable_cnt = 32. With 1 for only 0–2 → rsp = 0, unstable_cnt = 32.
- Hold rsp_ready low for 50 cycles in DONE and pulse start during that time:
  - rsp_valid stays high and rsp is stable; start is ignored;
  - raising rsp_ready returns busy to 0 one cycle later;
  - a new start is then accepted.
- Assert rst_n low during LAUNCH of bit 10:
  - all outputs go 0 asynchronously;
  - after release, state is IDLE and a fresh request completes with correct latency.
- seed = 0 → the LFSR loads 1 and behaviour matches the seed = 1 operand sequence.
